rf_write_arbiter: RTL and testbench

- Owns the single write port of the register file and drives its write address, write data and write-enable inputs.
- Merges two result sources:
  - the in-order pipeline writeback stage, which is never stalled;
  - a long-latency multi-cycle unit (mul/div/load-miss path), which is buffered in a small FIFO with a valid/ready handshake.
- Registers the write port and exports a bypass view of the in-flight write, plus a pending-destination bitmap for the hazard unit.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_wb_fifo.sv | 97 +++++++++
 rtl/rf_write_arbiter.sv | 115 +++++++++++
 tb/tb_rf_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write path.
//   RF_AW_DEFAULT / RF_DW_DEFAULT : default address / data widths
//   RF_ADDR_ZERO                  : hardwired zero register address
//   RF_WRITE_ENABLED / _DISABLED  : write-enable encodings
//   rf_wr_req_t                   : write request {addr, data} at default widths
package rf_pkg;

    localparam int unsigned RF_AW_DEFAULT = 5;
    localparam int unsigned RF_DW_DEFAULT = 32;

    localparam logic [RF_AW_DEFAULT-1:0] RF_ADDR_ZERO = '0;

    localparam logic RF_WRITE_ENABLED  = 1'b1;
    localparam logic RF_WRITE_DISABLED = 1'b0;

    typedef struct packed {
        logic [RF_AW_DEFAULT-1:0] addr;
        logic [RF_DW_DEFAULT-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry circular buffer of multi-cycle write results with
// per-entry valid bits that can be squashed by destination address.
//   clk, reset           : clock, async active-high reset
//   push, push_addr/data : enqueue at tail (caller guarantees !full)
//   pop                  : drop head entry (caller guarantees !empty)
//   squash, squash_addr  : invalidate every valid entry targeting squash_addr
//   head_valid/addr/data : head entry view (valid only if occupied and not squashed)
//   empty, full          : slot occupancy, including squashed slots
//   valid_count          : number of valid (unsquashed) entries
//   entry_valid/addr     : per-entry view for the pending-destination bitmap
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = RF_AW_DEFAULT,
    parameter int unsigned DW    = RF_DW_DEFAULT,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [AW-1:0]             push_addr,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    input  logic                      squash,
    input  logic [AW-1:0]             squash_addr,
    output logic                      head_valid,
    output logic [AW-1:0]             head_addr,
    output logic [DW-1:0]             head_data,
    output logic                      empty,
    output logic                      full,
    output logic [CW-1:0]             valid_count,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH-1:0][AW-1:0]  entry_addr
);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ_q;
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    // Later assignments win: the push of a new entry overrides any squash,
    // since the incoming result is newer than the pipeline write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ_q   <= '0;
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (squash && valid_q[i] && (addr_q[i] == squash_addr))
                    valid_q[i] <= 1'b0;
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CW'(1);
                2'b01:   occ_q <= occ_q - CW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign empty      = (occ_q == '0);
    assign full       = (occ_q == CW'(DEPTH));
    assign head_valid = !empty && valid_q[rd_ptr];
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];
    assign entry_valid = valid_q;

    always_comb begin
        valid_count = '0;
        entry_addr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_count   = valid_count + CW'(valid_q[i]);
            entry_addr[i] = addr_q[i];
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register-file write port, merging the
// never-stalled pipeline writeback with buffered multi-cycle results.
//   clk, reset                 : clock, async active-high reset
//   pipe_valid/addr/data       : pipeline writeback (highest priority)
//   mc_valid/ready/addr/data   : multi-cycle result handshake
//   write_enable/addr/data     : registered register-file write port
//   byp_addrN/hitN/dataN       : bypass lookup against the in-flight write
//   pending_mask               : bit r set while a valid queued result targets r
//   pending_count              : number of valid queued results
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = RF_AW_DEFAULT,
    parameter int unsigned DW    = RF_DW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_valid,
    input  logic [AW-1:0]            pipe_addr,
    input  logic [DW-1:0]            pipe_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [AW-1:0]            mc_addr,
    input  logic [DW-1:0]            mc_data,
    output logic                     write_enable,
    output logic [AW-1:0]            write_addr,
    output logic [DW-1:0]            write_data,
    input  logic [AW-1:0]            byp_addr1,
    input  logic [AW-1:0]            byp_addr2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DW-1:0]            byp_data1,
    output logic [DW-1:0]            byp_data2,
    output logic [2**AW-1:0]         pending_mask,
    output logic [$clog2(DEPTH):0]   pending_count
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ADDR_ZERO);

    logic                     pipe_fire;
    logic                     mc_push;
    logic                     fifo_pop;
    logic                     head_valid;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [DEPTH-1:0]         entry_valid;
    logic [DEPTH-1:0][AW-1:0] entry_addr;

    assign pipe_fire = pipe_valid && (pipe_addr != ZERO_ADDR);
    assign mc_ready  = !fifo_full;
    // Zero-register results complete the handshake but are never enqueued.
    assign mc_push   = mc_valid && mc_ready && (mc_addr != ZERO_ADDR);
    // A squashed head is discarded whenever present, even during a pipeline
    // write; a valid head waits while the pipeline owns the port.
    assign fifo_pop  = !fifo_empty && !(pipe_fire && head_valid);

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (mc_push),
        .push_addr   (mc_addr),
        .push_data   (mc_data),
        .pop         (fifo_pop),
        .squash      (pipe_fire),
        .squash_addr (pipe_addr),
        .head_valid  (head_valid),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .valid_count (pending_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_enable <= RF_WRITE_DISABLED;
            write_addr   <= '0;
            write_data   <= '0;
        end else if (pipe_fire) begin
            write_enable <= RF_WRITE_ENABLED;
            write_addr   <= pipe_addr;
            write_data   <= pipe_data;
        end else if (head_valid) begin
            write_enable <= RF_WRITE_ENABLED;
            write_addr   <= head_addr;
            write_data   <= head_data;
        end else begin
            write_enable <= RF_WRITE_DISABLED;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i])
                pending_mask[entry_addr[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign byp_hit1  = write_enable && (write_addr == byp_addr1) && (byp_addr1 != ZERO_ADDR);
    assign byp_hit2  = write_enable && (write_addr == byp_addr2) && (byp_addr2 != ZERO_ADDR);
    assign byp_data1 = byp_hit1 ? write_data : '0;
    assign byp_data2 = byp_hit2 ? write_data : '0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of rf_write_arbiter (DEPTH=2, AW=5, DW=32).
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  byp_addr1;
    logic [4:0]  byp_addr2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
    logic [31:0] pending_mask;
    logic [1:0]  pending_count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    rf_wr_req_t vec [10];

    rf_write_arbiter #(
        .DEPTH (2),
        .AW    (5),
        .DW    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_valid    (pipe_valid),
        .pipe_addr     (pipe_addr),
        .pipe_data     (pipe_data),
        .mc_valid      (mc_valid),
        .mc_ready      (mc_ready),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .byp_addr1     (byp_addr1),
        .byp_addr2     (byp_addr2),
        .byp_hit1      (byp_hit1),
        .byp_hit2      (byp_hit2),
        .byp_data1     (byp_data1),
        .byp_data2     (byp_data2),
        .pending_mask  (pending_mask),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        pipe_valid = 1'b0;
        pipe_addr  = 5'd0;
        pipe_data  = 32'h0;
        mc_valid   = 1'b0;
        mc_addr    = 5'd0;
        mc_data    = 32'h0;
        byp_addr1  = 5'd0;
        byp_addr2  = 5'd0;
        for (int k = 0; k < 10; k++) begin
            vec[k].addr = 5'(10 + k);
            vec[k].data = 32'h1000 + 32'(k) * 32'h11;
        end

        // Reset state
        tick();
        tick();
        chk("rst_we",    32'(write_enable),  32'h0);
        chk("rst_waddr", 32'(write_addr),    32'h0);
        chk("rst_wdata", write_data,         32'h0);
        chk("rst_count", 32'(pending_count), 32'h0);
        chk("rst_mask",  pending_mask,       32'h0);
        chk("rst_ready", 32'(mc_ready),      32'h1);
        reset = 1'b0;

        // Pipe only
        pipe_valid = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h11;
        tick();
        pipe_valid = 1'b0;
        byp_addr1 = 5'd3; byp_addr2 = 5'd4;
        #1;
        chk("pipe_we",    32'(write_enable), 32'h1);
        chk("pipe_waddr", 32'(write_addr),   32'h3);
        chk("pipe_wdata", write_data,        32'h11);
        chk("pipe_hit1",  32'(byp_hit1),     32'h1);
        chk("pipe_bdat1", byp_data1,         32'h11);
        chk("pipe_hit2",  32'(byp_hit2),     32'h0);
        chk("pipe_bdat2", byp_data2,         32'h0);
        tick();
        chk("idle_we",    32'(write_enable), 32'h0);
        chk("idle_waddr", 32'(write_addr),   32'h3);
        chk("idle_wdata", write_data,        32'h11);
        chk("idle_hit1",  32'(byp_hit1),     32'h0);

        // Priority and backpressure
        pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h101;
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hA;
        chk("bp_ready0", 32'(mc_ready), 32'h1);
        tick();
        pipe_addr = 5'd2; pipe_data = 32'h102;
        mc_addr = 5'd6; mc_data = 32'hB;
        chk("bp_ready1", 32'(mc_ready),      32'h1);
        chk("bp_count1", 32'(pending_count), 32'h1);
        chk("bp_mask1",  pending_mask,       32'h20);
        chk("bp_waddr1", 32'(write_addr),    32'h1);
        tick();
        pipe_addr = 5'd4; pipe_data = 32'h104;
        mc_addr = 5'd9; mc_data = 32'hC;
        chk("bp_ready2", 32'(mc_ready),      32'h0);
        chk("bp_count2", 32'(pending_count), 32'h2);
        chk("bp_mask2",  pending_mask,       32'h60);
        chk("bp_waddr2", 32'(write_addr),    32'h2);
        tick();
        chk("bp_ready3", 32'(mc_ready),      32'h0);
        chk("bp_count3", 32'(pending_count), 32'h2);
        chk("bp_wdata3", write_data,         32'h104);
        pipe_valid = 1'b0;
        mc_valid = 1'b0;
        tick();
        chk("bp_r5_we",   32'(write_enable),  32'h1);
        chk("bp_r5_addr", 32'(write_addr),    32'h5);
        chk("bp_r5_data", write_data,         32'hA);
        chk("bp_r5_cnt",  32'(pending_count), 32'h1);
        chk("bp_r5_mask", pending_mask,       32'h40);
        chk("bp_r5_rdy",  32'(mc_ready),      32'h1);
        tick();
        chk("bp_r6_addr", 32'(write_addr),    32'h6);
        chk("bp_r6_data", write_data,         32'hB);
        chk("bp_r6_cnt",  32'(pending_count), 32'h0);
        tick();
        chk("bp_end_we",  32'(write_enable),  32'h0);

        // Squash, then the next entry still drains after the stale head
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h70;
        tick();
        mc_addr = 5'd8; mc_data = 32'h80;
        pipe_valid = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h99;
        chk("sq_mask0", pending_mask, 32'h80);
        tick();
        mc_valid = 1'b0;
        pipe_valid = 1'b0;
        chk("sq_we",    32'(write_enable),  32'h1);
        chk("sq_addr",  32'(write_addr),    32'h7);
        chk("sq_data",  write_data,         32'h99);
        chk("sq_mask1", pending_mask,       32'h100);
        chk("sq_cnt1",  32'(pending_count), 32'h1);
        tick();
        chk("sq_skip_we",  32'(write_enable),  32'h0);
        chk("sq_skip_cnt", 32'(pending_count), 32'h1);
        tick();
        chk("sq_r8_we",   32'(write_enable),  32'h1);
        chk("sq_r8_addr", 32'(write_addr),    32'h8);
        chk("sq_r8_data", write_data,         32'h80);
        chk("sq_r8_cnt",  32'(pending_count), 32'h0);
        tick();
        chk("sq_end_we", 32'(write_enable), 32'h0);

        // Push of the same register in the squash edge survives
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h70;
        tick();
        mc_data = 32'h77;
        pipe_valid = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h99;
        tick();
        mc_valid = 1'b0;
        pipe_valid = 1'b0;
        chk("sp_mask",  pending_mask,       32'h80);
        chk("sp_cnt",   32'(pending_count), 32'h1);
        chk("sp_ready", 32'(mc_ready),      32'h0);
        tick();
        chk("sp_skip_we",  32'(write_enable), 32'h0);
        chk("sp_skip_rdy", 32'(mc_ready),     32'h1);
        tick();
        chk("sp_new_we",   32'(write_enable), 32'h1);
        chk("sp_new_addr", 32'(write_addr),   32'h7);
        chk("sp_new_data", write_data,        32'h77);
        tick();
        chk("sp_end_we",  32'(write_enable),  32'h0);
        chk("sp_end_cnt", 32'(pending_count), 32'h0);

        // Zero register on both sources
        pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h5;
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h6;
        byp_addr1 = 5'd0; byp_addr2 = 5'd7;
        chk("z_ready0", 32'(mc_ready), 32'h1);
        tick();
        pipe_valid = 1'b0;
        mc_valid = 1'b0;
        chk("z_we",    32'(write_enable),  32'h0);
        chk("z_cnt",   32'(pending_count), 32'h0);
        chk("z_mask",  pending_mask,       32'h0);
        chk("z_ready", 32'(mc_ready),      32'h1);
        chk("z_hit1",  32'(byp_hit1),      32'h0);
        chk("z_bdat1", byp_data1,          32'h0);
        chk("z_hit2",  32'(byp_hit2),      32'h0);

        // Wrap-around: 10 back-to-back pushes, each written one edge later
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                mc_valid = 1'b1;
                mc_addr  = vec[k].addr;
                mc_data  = vec[k].data;
            end else begin
                mc_valid = 1'b0;
            end
            chk("wrap_ready", 32'(mc_ready), 32'h1);
            tick();
            if (k >= 1) begin
                chk("wrap_we",   32'(write_enable), 32'h1);
                chk("wrap_addr", 32'(write_addr),   32'(vec[k-1].addr));
                chk("wrap_data", write_data,        vec[k-1].data);
            end
        end
        tick();
        chk("wrap_end_we",  32'(write_enable),  32'h0);
        chk("wrap_end_cnt", 32'(pending_count), 32'h0);

        // Asynchronous reset with two results queued
        pipe_valid = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h202;
        mc_valid = 1'b1; mc_addr = 5'd20; mc_data = 32'h2020;
        tick();
        mc_addr = 5'd21; mc_data = 32'h2121;
        tick();
        mc_valid = 1'b0;
        chk("rq_cnt",  32'(pending_count), 32'h2);
        chk("rq_mask", pending_mask,       32'h0030_0000);
        chk("rq_we",   32'(write_enable),  32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_we",    32'(write_enable),  32'h0);
        chk("ar_waddr", 32'(write_addr),    32'h0);
        chk("ar_wdata", write_data,         32'h0);
        chk("ar_cnt",   32'(pending_count), 32'h0);
        chk("ar_mask",  pending_mask,       32'h0);
        chk("ar_ready", 32'(mc_ready),      32'h1);
        pipe_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("ar_post_we",  32'(write_enable),  32'h0);
        chk("ar_post_cnt", 32'(pending_count), 32'h0);
        tick();
        chk("ar_post2_we", 32'(write_enable), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
